// File: rtl/display_select_if.sv
// Board-side signal bundle of display_select_ctrl: raw active-low keys in,
// display mux select/enable out. master = board/key side, slave = controller.
interface display_select_if;
  logic       KEY_Up_n;
  logic       KEY_Down_n;
  logic       KEY_Show_n;
  logic [4:0] Display_Select;
  logic       Display_Enable;
  logic       Select_Changed;

  modport master (
    output KEY_Up_n, KEY_Down_n, KEY_Show_n,
    input  Display_Select, Display_Enable, Select_Changed
  );

  modport slave (
    input  KEY_Up_n, KEY_Down_n, KEY_Show_n,
    output Display_Select, Display_Enable, Select_Changed
  );
endinterface

// File: rtl/display_select_ctrl.sv
// Pushbutton front end for the debug display mux: debounce three keys, step a
// wrapping selector, gate the display. Optional auto-advance: DISPLAY_AUTO_CYCLE_EN.
module display_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SEL_MAX         = 16,
  parameter int AUTO_PERIOD     = 50000000
) (
  input logic             Clock,
  input logic             Reset,
  display_select_if.slave bus
);

  localparam int            DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]    SEL_TOP  = 5'(SEL_MAX);

  if (SEL_MAX < 1 || SEL_MAX > 31 || DEBOUNCE_CYCLES < 1 || AUTO_PERIOD < 1) begin : g_param_check
    $error("display_select_ctrl: parameter out of range");
  end

  // Key index: 0 = up, 1 = down, 2 = show.
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    deb_q, deb_d;
  logic [DW-1:0] cnt_q [3];
  logic [DW-1:0] cnt_d [3];
  logic [1:0]    deb_dly_q, deb_dly_d;
  logic [1:0]    press_q, press_d;
  logic [4:0]    sel_q, sel_d;
  logic          enable_q, enable_d;
  logic          changed_q, changed_d;
  logic          key_up, key_dn;

  function automatic logic [4:0] sel_inc(input logic [4:0] s);
    return (s >= SEL_TOP) ? 5'd0 : s + 5'd1;
  endfunction

  function automatic logic [4:0] sel_dec(input logic [4:0] s);
    return (s == 5'd0) ? SEL_TOP : s - 5'd1;
  endfunction

  always_comb begin
    sync1_d   = {bus.KEY_Show_n, bus.KEY_Down_n, bus.KEY_Up_n};
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
    // Press is a 1->0 edge of the debounced state seen one cycle late.
    deb_dly_d = deb_q[1:0];
    press_d   = deb_dly_q & ~deb_q[1:0];
    enable_d  = ~deb_q[2];
  end

  assign key_up = press_q[0] & ~press_q[1];
  assign key_dn = press_q[1] & ~press_q[0];

`ifdef DISPLAY_AUTO_CYCLE_EN
  localparam int            AW        = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

  logic [AW-1:0] auto_cnt_q, auto_cnt_d;

  always_comb begin
    sel_d      = sel_q;
    changed_d  = 1'b0;
    auto_cnt_d = '0;
    if (key_up) begin
      sel_d     = sel_inc(sel_q);
      changed_d = 1'b1;
    end else if (key_dn) begin
      sel_d     = sel_dec(sel_q);
      changed_d = 1'b1;
    end else if (enable_q) begin
      if (auto_cnt_q == AUTO_LAST) begin
        sel_d     = sel_inc(sel_q);
        changed_d = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) auto_cnt_q <= '0;
    else       auto_cnt_q <= auto_cnt_d;
  end
`else
  always_comb begin
    sel_d     = sel_q;
    changed_d = 1'b0;
    if (key_up) begin
      sel_d     = sel_inc(sel_q);
      changed_d = 1'b1;
    end else if (key_dn) begin
      sel_d     = sel_dec(sel_q);
      changed_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q   <= 3'b111;
      sync2_q   <= 3'b111;
      deb_q     <= 3'b111;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      deb_dly_q <= 2'b11;
      press_q   <= 2'b00;
      sel_q     <= 5'd0;
      enable_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      deb_dly_q <= deb_dly_d;
      press_q   <= press_d;
      sel_q     <= sel_d;
      enable_q  <= enable_d;
      changed_q <= changed_d;
    end
  end

  assign bus.Display_Select = sel_q;
  assign bus.Display_Enable = enable_q;
  assign bus.Select_Changed = changed_q;

endmodule

// File: doc/display_select_ctrl.md
# display_select_ctrl

Pushbutton front end that drives the select/enable side of the debug display mux. Debounces three active-low board keys, steps a wrapping 5-bit display selector up or down, and asserts the display enable while the show key is held. Sits between the board KEY pins and the `Display_Select`/`Display_Enable` inputs of the display mux, all in the processor clock domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a key change is accepted (1 ms at 50 MHz).
- `SEL_MAX`, default 16: highest selector value, range 1..31.
- `AUTO_PERIOD`, default 50000000: auto-advance interval in cycles; used only with `DISPLAY_AUTO_CYCLE_EN`.

Ports:
- `Clock`  in  1  system clock; all logic on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `KEY_Up_n`  in  1  raw pushbutton, active low, asynchronous to `Clock`.
- `KEY_Down_n`  in  1  raw pushbutton, active low, asynchronous.
- `KEY_Show_n`  in  1  raw pushbutton, active low, asynchronous.
- `Display_Select`  out  5  current selector, registered.
- `Display_Enable`  out  1  high while show key is debounced-pressed, registered.
- `Select_Changed`  out  1  one-cycle pulse coincident with any `Display_Select` update.

## Operation
- One clock domain. Reset is synchronous and active-high.
- Per key: 2-flop synchronizer, reset to 1. Debounced state resets to 1, meaning released.
- Debounce: per-key counter clears whenever the synchronized value equals the debounced state. Otherwise it increments.
  - When it reaches `DEBOUNCE_CYCLES - 1` while the value still differs, the debounced state takes the synchronized value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles is ignored.
- Press event: debounced state goes 1→0; registered, one cycle wide. A release generates no event.
- Selector update on the cycle after a press event:
  - Up only: `SEL_MAX` → 0, else +1.
  - Down only: 0 → `SEL_MAX`, else −1.
  - Up and Down events in the same cycle: no change, no `Select_Changed`.
- `Display_Enable` = registered NOT of the debounced show state.
- Holding Up or Down never auto-repeats in the base build.
- Arithmetic: 5-bit unsigned. The selector never exceeds `SEL_MAX`.
- Reset mid-debounce or mid-press: all counters clear, the selector returns to 0, and a key still held after reset must re-debounce before it takes effect. A key held through reset produces one press event after debounce.

## Timing
- Reset values: `Display_Select`=0, `Display_Enable`=0, `Select_Changed`=0, internal counters 0, debounced and synchronized keys 1.
- Raw key edge (clean) sampled at cycle t:
  - Synchronized value at t+2.
  - Debounced state changes at t+2+`DEBOUNCE_CYCLES`.
  - Press event at t+3+`DEBOUNCE_CYCLES`.
  - `Display_Select` and `Select_Changed` update at t+4+`DEBOUNCE_CYCLES`.
  - `Display_Enable` follows the debounced show state with 1 cycle latency, at t+3+`DEBOUNCE_CYCLES`.
- `Select_Changed` is high for exactly the one cycle where `Display_Select` holds a new value. It is never high two cycles in a row from a single key.

## Configuration
- `DISPLAY_AUTO_CYCLE_EN` defined:
  - While `Display_Enable` is high, an auto counter advances the selector as for Up every `AUTO_PERIOD` cycles and pulses `Select_Changed`.
  - The counter clears when `Display_Enable` is low and on any key-driven selector update.
  - If a key event and auto-advance coincide, the key event wins and the auto counter clears.
- Not defined: no auto counter logic; `AUTO_PERIOD` is unused; the selector changes only on Up/Down events.

## Test plan
Use `DEBOUNCE_CYCLES`=4, `SEL_MAX`=16, `AUTO_PERIOD`=10.
- Reset for 2 cycles, then release Reset → `Display_Select`=0, `Display_Enable`=0, `Select_Changed`=0; no events with all keys high for 50 cycles.
- Press Up cleanly 3 times, each held 10 cycles → `Display_Select` goes 1, 2, 3, each step 8 cycles after the falling edge, with exactly 3 single-cycle `Select_Changed` pulses.
- From 0, press Down once → `Display_Select`=16. Then press Up once → 0 (both wraps).
- Glitch `KEY_Up_n` low for 3 cycles → no change. Hold low for 20 cycles → exactly one increment; no repeat while held.
- Press Up and Down with identical clean edges → `Display_Select` unchanged, no `Select_Changed`. Hold Show → `Display_Enable`=1 seven cycles after the edge, 0 seven cycles after release.
- With `DISPLAY_AUTO_CYCLE_EN`, hold Show for 45 cycles after enable rises → selector advances every 10 cycles (4 steps). Asserting Reset mid-hold forces 0/0/0 on the next edge.
